// File: rtl/scr1_brkm_bp_ctrl_pkg.sv
// BRKM breakpoint controller shared types.
// CTRL bit positions, CSR selector, break actions, FSM states.
package scr1_brkm_bp_ctrl_pkg;

    localparam int unsigned BRKM_CTRL_EXACT   = 0;
    localparam int unsigned BRKM_CTRL_MASK    = 1;
    localparam int unsigned BRKM_CTRL_MASKEXT = 2;
    localparam int unsigned BRKM_CTRL_ARM     = 3;
    localparam int unsigned BRKM_CTRL_ACT     = 4;
    localparam int unsigned BRKM_CTRL_HIT     = 6;
    localparam int unsigned BRKM_CTRL_PEND    = 7;
    localparam int unsigned BRKM_CTRL_THR     = 8;

    typedef enum logic [1:0] {
        BRKM_SEL_CTRL  = 2'b00,
        BRKM_SEL_LO    = 2'b01,
        BRKM_SEL_HI    = 2'b10,
        BRKM_SEL_COUNT = 2'b11
    } type_scr1_brkm_bp_sel_e;

    typedef enum logic [1:0] {
        BRKM_ACT_NONE = 2'b00,
        BRKM_ACT_EXC  = 2'b01,
        BRKM_ACT_HALT = 2'b10,
        BRKM_ACT_RSVD = 2'b11
    } type_scr1_brkm_action_e;

    typedef enum logic {
        BRKM_FSM_IDLE = 1'b0,
        BRKM_FSM_REQ  = 1'b1
    } type_scr1_brkm_fsm_e;

    localparam type_scr1_brkm_action_e BRKM_ACT_RST = BRKM_ACT_NONE;

endpackage

// File: rtl/scr1_brkm_bp_ctrl_chan.sv
// One BRKM breakpoint channel: config registers, hit counter, pending flag.
module scr1_brkm_bp_chan
    import scr1_brkm_bp_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int CW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  type_scr1_brkm_bp_sel_e wr_sel,
    input  logic [31:0]            wdata,
    input  logic                   match,
    input  logic                   ack,
    output logic                   exact_en,
    output logic                   mask_en,
    output logic                   mask_ext_en,
    output logic [AW-1:0]          addr_lo,
    output logic [AW-1:0]          addr_hi,
    output logic                   pending,
    output type_scr1_brkm_action_e action,
    output logic [31:0]            ctrl_word,
    output logic [CW-1:0]          count
);

    logic          cfg_exact;
    logic          cfg_mask;
    logic          cfg_ext;
    logic          arm;
    logic          hit;
    logic [CW-1:0] thr;
    logic [CW-1:0] thr_eff;
    logic [CW:0]   inc;
    logic [CW-1:0] cnt_sat;
    logic          reach;
    logic          count_en;
    logic          ctrl_wr;

    assign ctrl_wr  = wr_en & (wr_sel == BRKM_SEL_CTRL);
    assign thr_eff  = (thr == '0) ? CW'(1) : thr;
    assign inc      = {1'b0, count} + (CW + 1)'(1);
    assign reach    = inc >= {1'b0, thr_eff};
    assign cnt_sat  = (&count) ? count : inc[CW-1:0];
    assign count_en = match & arm & ~pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_exact <= 1'b0;
            cfg_mask  <= 1'b0;
            cfg_ext   <= 1'b0;
            arm       <= 1'b0;
            action    <= BRKM_ACT_RST;
            hit       <= 1'b0;
            pending   <= 1'b0;
            thr       <= '0;
            count     <= '0;
            addr_lo   <= '0;
            addr_hi   <= '0;
        end else if (ctrl_wr) begin
            cfg_exact <= wdata[BRKM_CTRL_EXACT];
            cfg_mask  <= wdata[BRKM_CTRL_MASK];
            cfg_ext   <= wdata[BRKM_CTRL_MASKEXT];
            arm       <= wdata[BRKM_CTRL_ARM];
            action    <= type_scr1_brkm_action_e'(wdata[BRKM_CTRL_ACT +: 2]);
            thr       <= wdata[BRKM_CTRL_THR +: CW];
            if (wdata[BRKM_CTRL_HIT]) begin
                hit <= 1'b0;
            end
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_sel)
                    BRKM_SEL_LO:    addr_lo <= wdata[AW-1:0];
                    BRKM_SEL_HI:    addr_hi <= wdata[AW-1:0];
                    BRKM_SEL_COUNT: count   <= wdata[CW-1:0];
                    default:        ;
                endcase
            end
            if (ack) begin
                pending <= 1'b0;
                hit     <= 1'b1;
                arm     <= 1'b0;
            end else if (count_en && !wr_en) begin
                if (reach) begin
                    count <= '0;
                    // trace-only channels never raise a break
                    if (action == BRKM_ACT_NONE) begin
                        hit <= 1'b1;
                    end else begin
                        pending <= 1'b1;
                    end
                end else begin
                    count <= cnt_sat;
                end
            end
        end
    end

    assign exact_en    = cfg_exact & arm;
    assign mask_en     = cfg_mask & arm;
    assign mask_ext_en = cfg_ext & arm;

    always_comb begin
        ctrl_word                        = '0;
        ctrl_word[BRKM_CTRL_EXACT]       = cfg_exact;
        ctrl_word[BRKM_CTRL_MASK]        = cfg_mask;
        ctrl_word[BRKM_CTRL_MASKEXT]     = cfg_ext;
        ctrl_word[BRKM_CTRL_ARM]         = arm;
        ctrl_word[BRKM_CTRL_ACT +: 2]    = action;
        ctrl_word[BRKM_CTRL_HIT]         = hit;
        ctrl_word[BRKM_CTRL_PEND]        = pending;
        ctrl_word[BRKM_CTRL_THR +: CW]   = thr;
    end

endmodule

// File: rtl/scr1_brkm_bp_ctrl.sv
// BRKM breakpoint controller: channel array, pending arbiter,
// req/ack break FSM towards the HDU and registered CSR read path.
module scr1_brkm_bp_ctrl
    import scr1_brkm_bp_ctrl_pkg::*;
#(
    parameter int BRKM_BP_NUM        = 2,
    parameter int BRKM_BP_ADDR_WIDTH = 32,
    parameter int BRKM_BP_CNT_WIDTH  = 8,
    localparam int NCH = BRKM_BP_NUM,
    localparam int AW  = BRKM_BP_ADDR_WIDTH,
    localparam int CW  = BRKM_BP_CNT_WIDTH,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     csr_req,
    input  logic                     csr_we,
    input  logic [CHW-1:0]           csr_ch,
    input  logic [1:0]               csr_sel,
    input  logic [31:0]              csr_wdata,
    output logic [31:0]              csr_rdata,
    input  logic [NCH-1:0]           bp_match,
    output logic [NCH-1:0]           bp_exact_en,
    output logic [NCH-1:0]           bp_mask_en,
    output logic [NCH-1:0]           bp_mask_ext_en,
    output logic [NCH-1:0][AW-1:0]   bp_addr_lo,
    output logic [NCH-1:0][AW-1:0]   bp_addr_hi,
    output logic                     brk_req,
    output logic [1:0]               brk_action,
    output logic [CHW-1:0]           brk_ch,
    input  logic                     brk_ack
);

    type_scr1_brkm_bp_sel_e sel;
    type_scr1_brkm_fsm_e    state;
    type_scr1_brkm_fsm_e    state_nx;
    type_scr1_brkm_action_e act_w [NCH];
    type_scr1_brkm_action_e act_q;
    type_scr1_brkm_action_e act_nx;
    logic [31:0]            ctrl_w [NCH];
    logic [CW-1:0]          cnt_w [NCH];
    logic [NCH-1:0]         pend;
    logic [NCH-1:0]         wr_en;
    logic [NCH-1:0]         ack_v;
    logic [CHW-1:0]         arb_ch;
    logic [CHW-1:0]         ch_q;
    logic [CHW-1:0]         ch_nx;
    logic                   ctrl_wr;
    logic                   cancel;
    logic                   idle_block;
    logic [31:0]            rd_mux;

    assign sel     = type_scr1_brkm_bp_sel_e'(csr_sel);
    assign ctrl_wr = csr_req & csr_we & (sel == BRKM_SEL_CTRL);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_en[i] = csr_req & csr_we & (csr_ch == CHW'(i));

        scr1_brkm_bp_chan #(
            .AW (AW),
            .CW (CW)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en       (wr_en[i]),
            .wr_sel      (sel),
            .wdata       (csr_wdata),
            .match       (bp_match[i]),
            .ack         (ack_v[i]),
            .exact_en    (bp_exact_en[i]),
            .mask_en     (bp_mask_en[i]),
            .mask_ext_en (bp_mask_ext_en[i]),
            .addr_lo     (bp_addr_lo[i]),
            .addr_hi     (bp_addr_hi[i]),
            .pending     (pend[i]),
            .action      (act_w[i]),
            .ctrl_word   (ctrl_w[i]),
            .count       (cnt_w[i])
        );
    end

    always_comb begin
        arb_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                arb_ch = CHW'(i);
            end
        end
    end

    // a CTRL write racing the latch would leave REQ pointing at a cleared channel
    assign idle_block = ctrl_wr & (csr_ch == arb_ch);
    assign cancel     = (state == BRKM_FSM_REQ) & ctrl_wr & (csr_ch == ch_q);

    always_comb begin
        state_nx = state;
        ch_nx    = ch_q;
        act_nx   = act_q;
        ack_v    = '0;
        unique case (state)
            BRKM_FSM_IDLE: begin
                if ((|pend) && !idle_block) begin
                    state_nx = BRKM_FSM_REQ;
                    ch_nx    = arb_ch;
                    act_nx   = act_w[arb_ch];
                end
            end
            BRKM_FSM_REQ: begin
                if (cancel) begin
                    state_nx = BRKM_FSM_IDLE;
                end else if (brk_ack) begin
                    state_nx    = BRKM_FSM_IDLE;
                    ack_v[ch_q] = 1'b1;
                end
            end
            default: state_nx = BRKM_FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BRKM_FSM_IDLE;
            ch_q  <= '0;
            act_q <= BRKM_ACT_RST;
        end else begin
            state <= state_nx;
            ch_q  <= ch_nx;
            act_q <= act_nx;
        end
    end

    assign brk_req    = (state == BRKM_FSM_REQ);
    assign brk_ch     = ch_q;
    assign brk_action = act_q;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (csr_ch == CHW'(i)) begin
                unique case (sel)
                    BRKM_SEL_CTRL:  rd_mux = ctrl_w[i];
                    BRKM_SEL_LO:    rd_mux = 32'(bp_addr_lo[i]);
                    BRKM_SEL_HI:    rd_mux = 32'(bp_addr_hi[i]);
                    BRKM_SEL_COUNT: rd_mux = 32'(cnt_w[i]);
                    default:        rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_rdata <= '0;
        end else if (csr_req && !csr_we) begin
            csr_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_scr1_brkm_bp_ctrl.sv
// Directed bench for the BRKM breakpoint controller with
// a scoreboard queue of expected values.
module tb_scr1_brkm_bp_ctrl;
    import scr1_brkm_bp_ctrl_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             csr_req = 1'b0;
    logic             csr_we = 1'b0;
    logic [0:0]       csr_ch = '0;
    logic [1:0]       csr_sel = '0;
    logic [31:0]      csr_wdata = '0;
    logic [31:0]      csr_rdata;
    logic [1:0]       bp_match = '0;
    logic [1:0]       bp_exact_en;
    logic [1:0]       bp_mask_en;
    logic [1:0]       bp_mask_ext_en;
    logic [1:0][31:0] bp_addr_lo;
    logic [1:0][31:0] bp_addr_hi;
    logic             brk_req;
    logic [1:0]       brk_action;
    logic [0:0]       brk_ch;
    logic             brk_ack = 1'b0;

    scr1_brkm_bp_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_req        (csr_req),
        .csr_we         (csr_we),
        .csr_ch         (csr_ch),
        .csr_sel        (csr_sel),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .bp_match       (bp_match),
        .bp_exact_en    (bp_exact_en),
        .bp_mask_en     (bp_mask_en),
        .bp_mask_ext_en (bp_mask_ext_en),
        .bp_addr_lo     (bp_addr_lo),
        .bp_addr_hi     (bp_addr_hi),
        .brk_req        (brk_req),
        .brk_action     (brk_action),
        .brk_ch         (brk_ch),
        .brk_ack        (brk_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: got %h required an expected entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        push(tag, exp);
        pop_cmp(obs);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [0:0] ch, input logic [1:0] s,
                      input logic [31:0] d);
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_ch    = ch;
        csr_sel   = s;
        csr_wdata = d;
        step();
        csr_req = 1'b0;
        csr_we  = 1'b0;
    endtask

    task automatic rd(input logic [0:0] ch, input logic [1:0] s,
                      input logic [31:0] exp, input string tag);
        push(tag, exp);
        csr_req = 1'b1;
        csr_we  = 1'b0;
        csr_ch  = ch;
        csr_sel = s;
        step();
        csr_req = 1'b0;
        pop_cmp(csr_rdata);
    endtask

    task automatic mt(input logic [1:0] m);
        bp_match = m;
        step();
        bp_match = '0;
    endtask

    task automatic ack();
        brk_ack = 1'b1;
        step();
        brk_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(brk_req), 0);
        chk("rst_exact_en", 32'(bp_exact_en), 0);
        chk("rst_rdata", csr_rdata, 0);
        rst_n = 1'b1;
        step();
        rd(0, BRKM_SEL_CTRL, 0, "rst_ctrl0");

        // ack while idle is ignored
        ack();
        chk("idle_ack", 32'(brk_req), 0);

        // T2: exact, arm, halt, thr=1
        wr(0, BRKM_SEL_CTRL, 32'h0129);
        chk("t2_exact_en", 32'(bp_exact_en[0]), 1);
        mt(2'b01);
        chk("t2_req_lat", 32'(brk_req), 0);
        step();
        chk("t2_req", 32'(brk_req), 1);
        chk("t2_ch", 32'(brk_ch), 0);
        chk("t2_act", 32'(brk_action), 32'(BRKM_ACT_HALT));
        ack();
        chk("t2_req_drop", 32'(brk_req), 0);
        rd(0, BRKM_SEL_CTRL, 32'h0161, "t2_ctrl");
        chk("t2_exact_off", 32'(bp_exact_en[0]), 0);

        // T3: thr=3, exception
        wr(1, BRKM_SEL_CTRL, 32'h0319);
        mt(2'b10);
        mt(2'b10);
        rd(1, BRKM_SEL_COUNT, 2, "t3_cnt2");
        chk("t3_noreq", 32'(brk_req), 0);
        mt(2'b10);
        chk("t3_req_lat", 32'(brk_req), 0);
        step();
        chk("t3_req", 32'(brk_req), 1);
        chk("t3_ch", 32'(brk_ch), 1);
        chk("t3_act", 32'(brk_action), 32'(BRKM_ACT_EXC));
        rd(1, BRKM_SEL_COUNT, 0, "t3_cnt0");
        ack();
        chk("t3_req_drop", 32'(brk_req), 0);
        wr(1, BRKM_SEL_CTRL, 32'h0059);
        mt(2'b10);
        step();
        chk("t3_thr0_req", 32'(brk_req), 1);
        ack();

        // T4: simultaneous threshold on ch0 and ch1
        wr(0, BRKM_SEL_CTRL, 32'h0169);
        wr(1, BRKM_SEL_CTRL, 32'h0159);
        mt(2'b11);
        step();
        chk("t4_req0", 32'(brk_req), 1);
        chk("t4_ch0", 32'(brk_ch), 0);
        chk("t4_act0", 32'(brk_action), 32'(BRKM_ACT_HALT));
        rd(1, BRKM_SEL_CTRL, 32'h0199, "t4_ch1_pend");
        ack();
        chk("t4_idle", 32'(brk_req), 0);
        step();
        chk("t4_req1", 32'(brk_req), 1);
        chk("t4_ch1", 32'(brk_ch), 1);
        chk("t4_act1", 32'(brk_action), 32'(BRKM_ACT_EXC));
        ack();
        chk("t4_done", 32'(brk_req), 0);

        // T5: CSR write wins over same-cycle match; cancel during REQ
        bp_match = 2'b01;
        wr(0, BRKM_SEL_CTRL, 32'h0169);
        bp_match = '0;
        step();
        chk("t5_nodrop_req", 32'(brk_req), 0);
        rd(0, BRKM_SEL_COUNT, 0, "t5_cnt");
        mt(2'b01);
        step();
        chk("t5_req", 32'(brk_req), 1);
        wr(0, BRKM_SEL_CTRL, 32'h0121);
        chk("t5_cancel", 32'(brk_req), 0);
        step();
        chk("t5_stay_idle", 32'(brk_req), 0);
        rd(0, BRKM_SEL_CTRL, 32'h0121, "t5_ctrl");

        // mask enable gating by arm
        wr(0, BRKM_SEL_CTRL, 32'h000E);
        chk("mask_en", 32'(bp_mask_en[0]), 1);
        chk("mask_ext_en", 32'(bp_mask_ext_en[0]), 1);
        chk("mask_exact", 32'(bp_exact_en[0]), 0);
        wr(0, BRKM_SEL_CTRL, 32'h0006);
        chk("mask_disarm", 32'({bp_mask_en[0], bp_mask_ext_en[0]}), 0);

        // T6: trace-only counting
        wr(1, BRKM_SEL_CTRL, 32'h0249);
        for (int i = 0; i < 5; i++) begin
            mt(2'b10);
            chk("t6_noreq", 32'(brk_req), 0);
        end
        step();
        chk("t6_noreq_end", 32'(brk_req), 0);
        rd(1, BRKM_SEL_CTRL, 32'h0249, "t6_ctrl");
        rd(1, BRKM_SEL_COUNT, 1, "t6_cnt");
        chk("t6_armed", 32'(bp_exact_en[1]), 1);

        // counter near the top of its range
        wr(1, BRKM_SEL_CTRL, 32'hFF49);
        wr(1, BRKM_SEL_COUNT, 32'h00FD);
        mt(2'b10);
        rd(1, BRKM_SEL_COUNT, 32'h00FE, "sat_fe");
        mt(2'b10);
        rd(1, BRKM_SEL_COUNT, 0, "sat_thr");
        rd(1, BRKM_SEL_CTRL, 32'hFF49, "sat_ctrl");
        wr(1, BRKM_SEL_COUNT, 32'h1234_56FF);
        rd(1, BRKM_SEL_COUNT, 32'h00FF, "cnt_width");
        mt(2'b10);
        rd(1, BRKM_SEL_COUNT, 0, "sat_ff");

        // address registers
        wr(1, BRKM_SEL_LO, 32'h1234_5678);
        chk("addr_lo", bp_addr_lo[1], 32'h1234_5678);
        wr(1, BRKM_SEL_HI, 32'h9ABC_DEF0);
        rd(1, BRKM_SEL_HI, 32'h9ABC_DEF0, "addr_hi");
        chk("addr_lo0", bp_addr_lo[0], 0);

        // T1: reset while a request is active
        wr(0, BRKM_SEL_CTRL, 32'h0129);
        wr(0, BRKM_SEL_COUNT, 32'h0000);
        mt(2'b01);
        step();
        chk("t1_req", 32'(brk_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_req_rst", 32'(brk_req), 0);
        chk("t1_en_rst", 32'({bp_exact_en, bp_mask_en, bp_mask_ext_en}), 0);
        step();
        rst_n = 1'b1;
        step();
        rd(0, BRKM_SEL_COUNT, 0, "t1_cnt");
        rd(0, BRKM_SEL_CTRL, 0, "t1_ctrl");
        rd(1, BRKM_SEL_HI, 0, "t1_hi");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
